// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, common widths and baud divider math.
package uart_pkg;

  localparam int DATA_W         = 8;
  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_RECOVER
  } rx_state_e;

  // Integer division; the residual baud error is left to the integrator.
  function automatic int calc_tick_div(input int clock_freq, input int baud_rate,
                                       input int oversample);
    return clock_freq / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte stream handshake between the receiver (master) and its consumer (slave).
interface uart_rx_if;
  import uart_pkg::*;

  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Oversample tick divider: one-clk tick every TICK_DIV clocks, restartable by clr.
module uart_baud_gen #(
  parameter int TICK_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 3-sample majority vote, single-entry holding register,
// framing/overrun pulses and an LED mirror of the last accepted byte.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  uart_rx_if.master         out_if,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy,
  output logic [DATA_W-1:0] leds
);

  localparam int TICK_DIV = calc_tick_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int SW       = $clog2(OVERSAMPLE);
  localparam int MID      = OVERSAMPLE / 2;
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_A    = SW'(MID - 1);
  localparam logic [SW-1:0] S_B    = SW'(MID);
  localparam logic [SW-1:0] S_C    = SW'(MID + 1);

  logic [1:0]        sync_q;
  logic              rxs;
  rx_state_e         state_q, state_d;
  logic [SW-1:0]     scnt_q, scnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [1:0]        samp_q, samp_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] leds_q, leds_d;
  logic              valid_q, valid_d;
  logic              fe_q, fe_d;
  logic              ov_q, ov_d;
  logic              tick, decide, wrap, maj, deliver;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx};
  end
  assign rxs = sync_q[1];

  uart_baud_gen #(.TICK_DIV(TICK_DIV)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == ST_IDLE),
    .tick (tick)
  );

  assign decide = tick && (scnt_q == S_C);
  assign wrap   = tick && (scnt_q == S_LAST);
  assign maj    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    samp_d  = samp_q;
    data_d  = data_q;
    leds_d  = leds_q;
    valid_d = valid_q;
    fe_d    = 1'b0;
    ov_d    = 1'b0;
    deliver = 1'b0;

    if (tick) begin
      scnt_d = (scnt_q == S_LAST) ? '0 : scnt_q + SW'(1);
      if (scnt_q == S_A) samp_d[0] = rxs;
      if (scnt_q == S_B) samp_d[1] = rxs;
    end

    case (state_q)
      ST_IDLE: begin
        scnt_d = '0;
        if (!rxs) state_d = ST_START;
      end
      ST_START: begin
        if (decide && maj) begin
          state_d = ST_IDLE;
        end else if (wrap) begin
          state_d = ST_DATA;
          idx_d   = 3'd0;
        end
      end
      ST_DATA: begin
        if (decide) shift_d[idx_q] = maj;
        if (wrap) begin
          if (idx_q == 3'd7) state_d = ST_STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      ST_STOP: begin
        // Leave at mid stop bit so a back-to-back start edge is not missed.
        if (decide) begin
          if (maj) begin
            deliver = 1'b1;
            state_d = ST_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = ST_RECOVER;
          end
        end
      end
      ST_RECOVER: begin
        if (rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (deliver) begin
      if (!valid_q || out_if.rx_ready) begin
        data_d  = shift_q;
        leds_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end else if (valid_q && out_if.rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      scnt_q  <= '0;
      idx_q   <= 3'd0;
      shift_q <= '0;
      samp_q  <= 2'b00;
      data_q  <= '0;
      leds_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      samp_q  <= samp_d;
      data_q  <= data_d;
      leds_q  <= leds_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  assign out_if.rx_data  = data_q;
  assign out_if.rx_valid = valid_q;
  assign frame_err       = fe_q;
  assign overrun         = ov_q;
  assign leds            = leds_q;
  assign busy            = (state_q != ST_IDLE);

endmodule
